// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 19-bit pipelined MIPS core: instruction width,
// the all-zero bubble instruction, fetch FSM encodings and opcode constants.
package mips_pipe_pkg;

   localparam int INST_W = 19;
   localparam int OP_W   = 4;

   // A bubble is the all-zero word: opcode 0 with destination register 0,
   // so downstream hazard logic never sees a dependency on it.
   localparam logic [INST_W-1:0] NOP_INST = 19'b0;

   typedef enum logic [1:0] {
      FS_RUN      = 2'd0,
      FS_STALL    = 2'd1,
      FS_REDIRECT = 2'd2
   } fetch_state_e;

   // Opcodes live in the top OP_W bits of the instruction.
   localparam logic [OP_W-1:0] OP_RTYPE = 4'h0;
   localparam logic [OP_W-1:0] OP_ADDI  = 4'h1;
   localparam logic [OP_W-1:0] OP_LW    = 4'h2;
   localparam logic [OP_W-1:0] OP_SW    = 4'h3;
   localparam logic [OP_W-1:0] OP_BEQ   = 4'h4;
   localparam logic [OP_W-1:0] OP_BNE   = 4'h5;
   localparam logic [OP_W-1:0] OP_JMP   = 4'h6;

   function automatic logic [OP_W-1:0] inst_opcode(input logic [INST_W-1:0] inst);
      return inst[INST_W-1 -: OP_W];
   endfunction

   function automatic logic inst_is_bubble(input logic [INST_W-1:0] inst);
      return (inst == NOP_INST);
   endfunction

endpackage

// File: rtl/if_id_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+1 and valid, with flush (load a
// bubble), load and hold controls. Flush outranks load.
module if_id_reg
   import mips_pipe_pkg::*;
#(
   parameter int PC_W   = 12,
   parameter int INST_W = mips_pipe_pkg::INST_W
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic              i_flush,
   input  logic [INST_W-1:0] i_instruction,
   input  logic [PC_W-1:0]   i_pc_plus1,
   output logic [INST_W-1:0] o_instruction,
   output logic [PC_W-1:0]   o_pc_plus1,
   output logic              o_valid
);

   logic [INST_W-1:0] r_instruction;
   logic [PC_W-1:0]   r_pc_plus1;
   logic              r_valid;

   // Register update: reset, then bubble insertion, then load, else hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_instruction <= INST_W'(NOP_INST);
         r_pc_plus1    <= '0;
         r_valid       <= 1'b0;
      end else if (i_flush) begin
         r_instruction <= INST_W'(NOP_INST);
         r_pc_plus1    <= '0;
         r_valid       <= 1'b0;
      end else if (i_load) begin
         r_instruction <= i_instruction;
         r_pc_plus1    <= i_pc_plus1;
         r_valid       <= 1'b1;
      end else begin
         r_instruction <= r_instruction;
         r_pc_plus1    <= r_pc_plus1;
         r_valid       <= r_valid;
      end
   end

   assign o_instruction = r_instruction;
   assign o_pc_plus1    = r_pc_plus1;
   assign o_valid       = r_valid;

endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage plus IF/ID register. Owns the PC, applies branch/jump redirects
// and hazard controls, tracks RUN/STALL/REDIRECT and a sticky stall watchdog.
// Optional build macro FETCH_STATS_EN adds saturating stall/bubble counters.
module if_id_fetch_stage
   import mips_pipe_pkg::*;
#(
   parameter int PC_W      = 12,
   parameter int INST_W    = mips_pipe_pkg::INST_W,
   parameter int MAX_STALL = 15
)
(
   input  logic              clk,
   input  logic              reset,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [INST_W-1:0] imem_data,
   input  logic              pc_writebar,
   input  logic              IF_ID_loadbar,
   input  logic              IF_ID_flush,
   input  logic              do_branch,
   input  logic [PC_W-1:0]   branch_target,
   input  logic              jump,
   input  logic [PC_W-1:0]   jump_target,
   output logic [PC_W-1:0]   pc,
   output logic [INST_W-1:0] IF_ID_instruction,
   output logic [PC_W-1:0]   IF_ID_pc_plus1,
   output logic              IF_ID_valid,
   output logic [1:0]        fetch_state,
   output logic              stall_timeout
`ifdef FETCH_STATS_EN
   ,
   output logic [15:0]       stat_stall_cycles,
   output logic [15:0]       stat_bubbles
`endif
);

   localparam logic [PC_W-1:0] PC_ONE      = PC_W'(1);
   localparam logic [7:0]      MAX_STALL_C = 8'(MAX_STALL);

   logic [PC_W-1:0] r_pc;
   fetch_state_e    r_state;
   fetch_state_e    w_state_next;
   logic [7:0]      r_stall_cnt;
   logic [7:0]      w_stall_cnt_next;
   logic            r_stall_timeout;
   logic            w_redirect;
   logic [PC_W-1:0] w_redirect_target;
   logic [PC_W-1:0] w_pc_plus1;
   logic [PC_W-1:0] w_pc_next;
   logic            w_bubble;
   logic            w_load;

   assign w_redirect        = do_branch | jump;
   assign w_redirect_target = do_branch ? branch_target : jump_target;
   assign w_pc_plus1        = r_pc + PC_ONE;   // wraps modulo 2^PC_W
   // A redirect squashes the wrong-path fetch regardless of stall controls.
   assign w_bubble          = w_redirect | IF_ID_flush;
   assign w_load            = ~IF_ID_loadbar;

   // Next PC: redirect beats stall; otherwise advance unless held.
   always_comb begin
      w_pc_next = r_pc;
      if (w_redirect) begin
         w_pc_next = w_redirect_target;
      end else if (!pc_writebar) begin
         w_pc_next = w_pc_plus1;
      end else begin
         w_pc_next = r_pc;
      end
   end

   // Next FSM state: redirect, then stall, else run.
   always_comb begin
      w_state_next = FS_RUN;
      if (w_redirect) begin
         w_state_next = FS_REDIRECT;
      end else if (pc_writebar) begin
         w_state_next = FS_STALL;
      end else begin
         w_state_next = FS_RUN;
      end
   end

   // Stall counter: count STALL->STALL edges (saturating), clear otherwise.
   always_comb begin
      w_stall_cnt_next = 8'd0;
      if ((r_state == FS_STALL) && (w_state_next == FS_STALL)) begin
         if (r_stall_cnt != 8'hFF) begin
            w_stall_cnt_next = r_stall_cnt + 8'd1;
         end else begin
            w_stall_cnt_next = r_stall_cnt;
         end
      end else begin
         w_stall_cnt_next = 8'd0;
      end
   end

   // PC, FSM state, stall counter and sticky watchdog registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc            <= '0;
         r_state         <= FS_RUN;
         r_stall_cnt     <= 8'd0;
         r_stall_timeout <= 1'b0;
      end else begin
         r_pc            <= w_pc_next;
         r_state         <= w_state_next;
         r_stall_cnt     <= w_stall_cnt_next;
         r_stall_timeout <= r_stall_timeout | (w_stall_cnt_next >= MAX_STALL_C);
      end
   end

   if_id_reg #(
      .PC_W   (PC_W),
      .INST_W (INST_W)
   ) u_if_id_reg (
      .clk           (clk),
      .reset         (reset),
      .i_load        (w_load),
      .i_flush       (w_bubble),
      .i_instruction (imem_data),
      .i_pc_plus1    (w_pc_plus1),
      .o_instruction (IF_ID_instruction),
      .o_pc_plus1    (IF_ID_pc_plus1),
      .o_valid       (IF_ID_valid)
   );

   assign imem_addr     = r_pc;
   assign pc            = r_pc;
   assign fetch_state   = r_state;
   assign stall_timeout = r_stall_timeout;

`ifdef FETCH_STATS_EN
   logic [15:0] r_stat_stall_cycles;
   logic [15:0] r_stat_bubbles;

   // Saturating counters of held-PC edges and bubble insertions.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_stall_cycles <= 16'd0;
         r_stat_bubbles      <= 16'd0;
      end else begin
         if (pc_writebar && !w_redirect && (r_stat_stall_cycles != 16'hFFFF)) begin
            r_stat_stall_cycles <= r_stat_stall_cycles + 16'd1;
         end else begin
            r_stat_stall_cycles <= r_stat_stall_cycles;
         end
         if (w_bubble && (r_stat_bubbles != 16'hFFFF)) begin
            r_stat_bubbles <= r_stat_bubbles + 16'd1;
         end else begin
            r_stat_bubbles <= r_stat_bubbles;
         end
      end
   end

   assign stat_stall_cycles = r_stat_stall_cycles;
   assign stat_bubbles      = r_stat_bubbles;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: each stimulus step pushes the
// hand-computed post-edge outputs; a monitor pops and compares after each edge.
module tb_if_id_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] imem_addr;
   logic [18:0] imem_data;
   logic        pc_writebar, IF_ID_loadbar, IF_ID_flush;
   logic        do_branch, jump;
   logic [11:0] branch_target, jump_target;
   logic [11:0] pc;
   logic [18:0] IF_ID_instruction;
   logic [11:0] IF_ID_pc_plus1;
   logic        IF_ID_valid;
   logic [1:0]  fetch_state;
   logic        stall_timeout;
`ifdef FETCH_STATS_EN
   logic [15:0] stat_stall_cycles, stat_bubbles;
`endif

   typedef struct {
      int idx;
      int e_pc, e_inst, e_pp1, e_v, e_st, e_to, e_ss, e_sb;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_step  = 0;

   always #5 clk = ~clk;

   // ROM model: imem[n] = n + 0x100
   assign imem_data = 19'h100 + {7'd0, imem_addr};

   if_id_fetch_stage #(.PC_W(12), .INST_W(19), .MAX_STALL(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .imem_addr         (imem_addr),
      .imem_data         (imem_data),
      .pc_writebar       (pc_writebar),
      .IF_ID_loadbar     (IF_ID_loadbar),
      .IF_ID_flush       (IF_ID_flush),
      .do_branch         (do_branch),
      .branch_target     (branch_target),
      .jump              (jump),
      .jump_target       (jump_target),
      .pc                (pc),
      .IF_ID_instruction (IF_ID_instruction),
      .IF_ID_pc_plus1    (IF_ID_pc_plus1),
      .IF_ID_valid       (IF_ID_valid),
      .fetch_state       (fetch_state),
      .stall_timeout     (stall_timeout)
`ifdef FETCH_STATS_EN
      ,
      .stat_stall_cycles (stat_stall_cycles),
      .stat_bubbles      (stat_bubbles)
`endif
   );

   function automatic void chk(input int idx, input string nm, input int act, input int exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", idx, nm, act, exp_v);
      end
   endfunction

   // Drive one cycle of inputs and queue the expected post-edge outputs.
   task automatic step(input logic rst, input logic pcwb, input logic lb, input logic fl,
                       input logic br, input int bt, input logic jp, input int jt,
                       input int e_pc, input int e_inst, input int e_pp1, input int e_v,
                       input int e_st, input int e_to, input int e_ss, input int e_sb);
      exp_t e;
      reset         = rst;
      pc_writebar   = pcwb;
      IF_ID_loadbar = lb;
      IF_ID_flush   = fl;
      do_branch     = br;
      branch_target = 12'(bt);
      jump          = jp;
      jump_target   = 12'(jt);
      e.idx = n_step; e.e_pc = e_pc; e.e_inst = e_inst; e.e_pp1 = e_pp1; e.e_v = e_v;
      e.e_st = e_st; e.e_to = e_to; e.e_ss = e_ss; e.e_sb = e_sb;
      exp_q.push_back(e);
      n_step++;
      @(negedge clk);
   endtask

   task automatic run(input int e_pc, input int e_inst, input int e_pp1, input int e_to);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, e_pc, e_inst, e_pp1, 1, 0, e_to, -1, -1);
   endtask

   // Monitor: after every rising edge, compare against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(e.idx, "pc",        int'(pc),                e.e_pc);
            chk(e.idx, "imem_addr", int'(imem_addr),         e.e_pc);
            chk(e.idx, "inst",      int'(IF_ID_instruction), e.e_inst);
            chk(e.idx, "pc_plus1",  int'(IF_ID_pc_plus1),    e.e_pp1);
            chk(e.idx, "valid",     int'(IF_ID_valid),       e.e_v);
            chk(e.idx, "state",     int'(fetch_state),       e.e_st);
            chk(e.idx, "timeout",   int'(stall_timeout),     e.e_to);
`ifdef FETCH_STATS_EN
            if (e.e_ss >= 0) chk(e.idx, "stat_stall", int'(stat_stall_cycles), e.e_ss);
            if (e.e_sb >= 0) chk(e.idx, "stat_bubbles", int'(stat_bubbles), e.e_sb);
`endif
         end
      end
   end

   initial begin
      // Reset
      step(1,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0);
      step(1,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0);
      // Free run: 0x100, 0x101, ... with PC+1 = 1, 2, ...
      for (int i = 1; i <= 5; i++) run(i, 'h100 + i - 1, i, 0);
      // Stall at pc=5 with IF/ID held for 3 cycles
      for (int i = 0; i < 3; i++) step(0,1,1,0, 0,0,0,0, 5,'h104,5,1,1,0, -1,-1);
      run(6, 'h105, 6, 0);
      run(7, 'h106, 7, 0);
      // Branch and jump together while stalled: branch wins, redirect beats stall
      step(0,1,1,0, 1,'h40,1,'h80, 'h40,0,0,0,2,0, -1,-1);
      run('h41, 'h140, 'h41, 0);
      // Jump alone
      step(0,0,0,0, 0,0,1,'h80, 'h80,0,0,0,2,0, -1,-1);
      run('h81, 'h180, 'h81, 0);
      // Flush without stall, then flush with PC held
      step(0,0,0,1, 0,0,0,0, 'h82,0,0,0,0,0, -1,-1);
      run('h83, 'h182, 'h83, 0);
      step(0,1,0,1, 0,0,0,0, 'h83,0,0,0,1,0, -1,-1);
      run('h84, 'h183, 'h84, 0);
      // PC held but IF/ID loading: same instruction re-latched
      step(0,1,0,0, 0,0,0,0, 'h84,'h184,'h85,1,1,0, -1,-1);
      step(0,1,0,0, 0,0,0,0, 'h84,'h184,'h85,1,1,0, -1,-1);
      run('h85, 'h184, 'h85, 0);
      // IF/ID held while PC advances
      step(0,0,1,0, 0,0,0,0, 'h86,'h184,'h85,1,0,0, -1,-1);
      run('h87, 'h186, 'h87, 0);
      // Watchdog: counter reaches 4 on the 5th stall edge
      for (int i = 1; i <= 6; i++)
         step(0,1,1,0, 0,0,0,0, 'h87,'h186,'h87,1,1,(i >= 5) ? 1 : 0, -1,-1);
      run('h88, 'h187, 'h88, 1);
      run('h89, 'h188, 'h89, 1);
      // PC wrap at 0xFFF
      step(0,0,0,0, 0,0,1,'hFFF, 'hFFF,0,0,0,2,1, -1,-1);
      run(0, 'h10FF, 0, 1);
      run(1, 'h100, 1, 1);
      // Reset during stall with redirect pending
      step(0,1,1,0, 0,0,0,0, 1,'h100,1,1,1,1, -1,-1);
      step(1,1,1,0, 1,'h40,0,0, 0,0,0,0,0,0, 0,0);
      step(0,0,0,0, 0,0,0,0, 1,'h100,1,1,0,0, 0,0);
      // Single flush pulse, then one stall edge
      step(0,0,0,1, 0,0,0,0, 2,0,0,0,0,0, 0,1);
      step(0,1,1,0, 0,0,0,0, 2,0,0,0,1,0, 1,1);
      run(3, 'h102, 3, 0);
      @(negedge clk);
      @(negedge clk);
      chk(n_step, "scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
